// File: rtl/servo_pkg.sv
// Shared defaults and arithmetic helpers for the servo bank.
package servo_pkg;

  localparam int DEF_NUM_CH     = 6;
  localparam int DEF_DUTY_W     = 7;
  localparam int DEF_DUTY_MAX   = 99;
  localparam int DEF_PRESCALE   = 1000;
  localparam int DEF_JOG_DIV    = 5000000;
  localparam int DEF_SLEW_STEP  = 1;
  localparam int DEF_RESET_DUTY = 0;

  // Bits needed to index n values, never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the channel address.
  function automatic int ch_w(input int n);
    return idx_w(n);
  endfunction

  // Jog one unit up or down, clamped to 0..max_v; both or neither holds.
  function automatic int sat_step(input int v, input logic up, input logic dn,
                                  input int max_v);
    if (up && !dn) return (v >= max_v) ? max_v : v + 1;
    if (dn && !up) return (v <= 0) ? 0 : v - 1;
    return v;
  endfunction

  // Move cur toward tgt by at most step, landing exactly on tgt.
  function automatic int slew_step(input int cur, input int tgt, input int step);
    if (cur < tgt) return (tgt - cur > step) ? cur + step : tgt;
    if (cur > tgt) return (cur - tgt > step) ? cur - step : tgt;
    return cur;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One PWM channel: period-latched shadow duty and registered comparator.
module servo_pwm_channel #(
  parameter int DUTY_W     = 7,
  parameter int STEP_W     = 7,
  parameter int RESET_DUTY = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              period_start,
  input  logic [DUTY_W-1:0] duty,
  input  logic [STEP_W-1:0] step,
  output logic              pwm
);

  logic [DUTY_W-1:0] shadow_q, shadow_d;
  logic              pwm_q, pwm_d;

  // Latch duty only at the period start so a period never changes mid-way.
  always_comb begin
    shadow_d = period_start ? duty : shadow_q;
    pwm_d    = (int'(step) < int'(shadow_d));
  end

  // Shadow and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q <= DUTY_W'(RESET_DUTY);
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/servo_bank.sv
// Multi-channel servo controller: joystick jog, processor writes,
// slew-limited current duty and registered PWM per channel.
module servo_bank
  import servo_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DUTY_W     = DEF_DUTY_W,
  parameter int DUTY_MAX   = DEF_DUTY_MAX,
  parameter int PRESCALE   = DEF_PRESCALE,
  parameter int JOG_DIV    = DEF_JOG_DIV,
  parameter int SLEW_STEP  = DEF_SLEW_STEP,
  parameter int RESET_DUTY = DEF_RESET_DUTY,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              js_u,
  input  logic              js_d,
  input  logic              js_l,
  input  logic              js_r,
  input  logic              mode,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_addr,
  input  logic [DUTY_W-1:0] wr_data,
  input  logic [CH_W-1:0]   rd_addr,
  output logic [DUTY_W-1:0] rd_data,
  output logic [CH_W-1:0]   sel,
  output logic              tick,
  output logic [NUM_CH-1:0] pwm
);

  localparam int PS_W = idx_w(PRESCALE);
  localparam int TK_W = idx_w(JOG_DIV);
  localparam int ST_W = idx_w(DUTY_MAX + 1);

  // Button order in the synchronizer vectors: {u, d, l, r}.
  logic [3:0]                   js_meta_q, js_sync_q;
  logic [TK_W-1:0]              tick_cnt_q, tick_cnt_d;
  logic [CH_W-1:0]              sel_q, sel_d;
  logic [NUM_CH-1:0][DUTY_W-1:0] target_q, target_d;
  logic [NUM_CH-1:0][DUTY_W-1:0] current_q, current_d;
  logic [PS_W-1:0]              ps_q, ps_d;
  logic [ST_W-1:0]              step_q, step_d;
  logic                         jog_en, ju, jd, jl, jr, ps_wrap, period_start;

  // Tick divider and jog selection.
  always_comb begin
    tick       = (tick_cnt_q == TK_W'(JOG_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    {ju, jd, jl, jr} = js_sync_q;
    jog_en     = tick && !mode;
    sel_d      = sel_q;
    if (jog_en && jr && !jl)
      sel_d = (sel_q == CH_W'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
    else if (jog_en && jl && !jr)
      sel_d = (sel_q == '0) ? CH_W'(NUM_CH - 1) : sel_q - 1'b1;
  end

  // Targets (jog then write, so a write wins) and slew from pre-tick targets.
  always_comb begin
    target_d  = target_q;
    current_d = current_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (tick)
        current_d[i] = DUTY_W'(slew_step(int'(current_q[i]), int'(target_q[i]),
                                         SLEW_STEP));
      if (jog_en && (CH_W'(i) == sel_q))
        target_d[i] = DUTY_W'(sat_step(int'(target_q[i]), ju, jd, DUTY_MAX));
      if (wr_en && (CH_W'(i) == wr_addr))
        target_d[i] = (int'(wr_data) > DUTY_MAX) ? DUTY_W'(DUTY_MAX) : wr_data;
    end
  end

  // PWM prescaler/step counters; period start is when both wrap to zero.
  always_comb begin
    ps_wrap = (ps_q == PS_W'(PRESCALE - 1));
    ps_d    = ps_wrap ? '0 : ps_q + 1'b1;
    step_d  = step_q;
    if (ps_wrap)
      step_d = (step_q == ST_W'(DUTY_MAX)) ? '0 : step_q + 1'b1;
    period_start = (ps_d == '0) && (step_d == '0);
  end

  // Readback mux; unmapped addresses return zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (CH_W'(i) == rd_addr) rd_data = current_q[i];
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      js_meta_q  <= '0;
      js_sync_q  <= '0;
      tick_cnt_q <= '0;
      sel_q      <= '0;
      target_q   <= {NUM_CH{DUTY_W'(RESET_DUTY)}};
      current_q  <= {NUM_CH{DUTY_W'(RESET_DUTY)}};
      ps_q       <= '0;
      step_q     <= '0;
    end else begin
      js_meta_q  <= {js_u, js_d, js_l, js_r};
      js_sync_q  <= js_meta_q;
      tick_cnt_q <= tick_cnt_d;
      sel_q      <= sel_d;
      target_q   <= target_d;
      current_q  <= current_d;
      ps_q       <= ps_d;
      step_q     <= step_d;
    end
  end

  assign sel = sel_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    servo_pwm_channel #(
      .DUTY_W    (DUTY_W),
      .STEP_W    (ST_W),
      .RESET_DUTY(RESET_DUTY)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .period_start(period_start),
      .duty        (current_q[g]),
      .step        (step_d),
      .pwm         (pwm[g])
    );
  end

endmodule

// File: tb/tb_servo_bank.sv
// Directed bench for servo_bank with a small 3-channel configuration.
module tb_servo_bank;

  localparam int NUM_CH = 3;
  localparam int DUTY_W = 7;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              js_u = 1'b0, js_d = 1'b0, js_l = 1'b0, js_r = 1'b0;
  logic              mode = 1'b0;
  logic              wr_en = 1'b0;
  logic [1:0]        wr_addr = '0;
  logic [DUTY_W-1:0] wr_data = '0;
  logic [1:0]        rd_addr = '0;
  logic [DUTY_W-1:0] rd_data;
  logic [1:0]        sel;
  logic              tick;
  logic [NUM_CH-1:0] pwm;

  int n_checks = 0;
  int n_fail   = 0;

  servo_bank #(
    .NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .DUTY_MAX(9), .PRESCALE(1),
    .JOG_DIV(4), .SLEW_STEP(2), .RESET_DUTY(0)
  ) dut (
    .clock(clock), .reset(reset),
    .js_u(js_u), .js_d(js_d), .js_l(js_l), .js_r(js_r),
    .mode(mode), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .sel(sel), .tick(tick), .pwm(pwm)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] addr;
    logic [6:0] data;
    int         e0, e1, e2;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    {js_u, js_d, js_l, js_r} = 4'b0;
    wr_en = 1'b0;
    mode  = 1'b0;
    reset = 1'b1;
    step_clk();
    step_clk();
    reset = 1'b0;
  endtask

  // Advance past the next tick edge so post-tick state is visible.
  task automatic wait_tick();
    int n = 0;
    do begin
      step_clk();
      n++;
    end while (!tick && n < 16);
    if (!tick) chk("tick_timeout", 0, 1);
    step_clk();
  endtask

  task automatic rd_chk(input string name, input int ch, input int exp);
    rd_addr = 2'(ch);
    #1;
    chk(name, int'(rd_data), exp);
  endtask

  task automatic write(input int ch, input int val);
    wr_en   = 1'b1;
    wr_addr = 2'(ch);
    wr_data = 7'(val);
    step_clk();
    wr_en   = 1'b0;
  endtask

  task automatic count_high(input int ch, output int cnt);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step_clk();
      cnt += int'(pwm[ch]);
    end
  endtask

  initial begin
    int cnt;
    vecs[0] = '{addr: 2'd1, data: 7'd5,  e0: 0, e1: 5, e2: 0};
    vecs[1] = '{addr: 2'd0, data: 7'd15, e0: 9, e1: 0, e2: 0};
    vecs[2] = '{addr: 2'd2, data: 7'd9,  e0: 0, e1: 0, e2: 9};
    vecs[3] = '{addr: 2'd3, data: 7'd7,  e0: 0, e1: 0, e2: 0};
    vecs[4] = '{addr: 2'd0, data: 7'd0,  e0: 0, e1: 0, e2: 0};
    vecs[5] = '{addr: 2'd1, data: 7'd1,  e0: 0, e1: 1, e2: 0};

    // Reset state.
    do_reset();
    chk("rst_sel", int'(sel), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_pwm", int'(pwm), 0);
    for (int c = 0; c < 4; c++) rd_chk("rst_rd", c, 0);

    // Table: write from reset, let slew settle, read every address.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      write(int'(vecs[v].addr), int'(vecs[v].data));
      for (int t = 0; t < 6; t++) wait_tick();
      rd_chk("vec_ch0", 0, vecs[v].e0);
      rd_chk("vec_ch1", 1, vecs[v].e1);
      rd_chk("vec_ch2", 2, vecs[v].e2);
      rd_chk("vec_ch3", 3, 0);
    end

    // Slew 0 -> 5 at step 2, then PWM duty 5/10.
    do_reset();
    write(1, 5);
    rd_addr = 2'd1;
    wait_tick(); rd_chk("slew_a", 1, 2);
    wait_tick(); rd_chk("slew_b", 1, 4);
    wait_tick(); rd_chk("slew_c", 1, 5);
    wait_tick(); rd_chk("slew_d", 1, 5);
    repeat (20) step_clk();
    count_high(1, cnt); chk("pwm1_high", cnt, 5);
    count_high(0, cnt); chk("pwm0_idle", cnt, 0);

    // Clamp at DUTY_MAX: one low step per period.
    write(0, 15);
    for (int t = 0; t < 6; t++) wait_tick();
    rd_chk("clamp_rd", 0, 9);
    repeat (12) step_clk();
    count_high(0, cnt); chk("pwm0_max", cnt, 9);

    // Channel select: R wraps forward, L wraps back, L+R holds.
    do_reset();
    wait_tick();
    js_r = 1'b1;
    wait_tick(); chk("sel_r1", int'(sel), 1);
    wait_tick(); chk("sel_r2", int'(sel), 2);
    wait_tick(); chk("sel_r3", int'(sel), 0);
    wait_tick(); chk("sel_r4", int'(sel), 1);
    js_r = 1'b0; js_l = 1'b1;
    wait_tick(); chk("sel_l1", int'(sel), 0);
    wait_tick(); chk("sel_l2", int'(sel), 2);
    js_r = 1'b1;
    wait_tick(); chk("sel_lr", int'(sel), 2);
    js_r = 1'b0; js_l = 1'b0;

    // Jog duty on ch2: saturate up, step down, U+D holds, mode=1 ignores.
    js_u = 1'b1;
    for (int t = 0; t < 12; t++) wait_tick();
    rd_chk("jog_sat", 2, 9);
    js_u = 1'b0; js_d = 1'b1;
    for (int t = 0; t < 3; t++) wait_tick();
    rd_chk("jog_down", 2, 7);
    js_u = 1'b1;
    for (int t = 0; t < 3; t++) wait_tick();
    rd_chk("jog_ud", 2, 6);
    mode = 1'b1; js_d = 1'b0; js_r = 1'b1;
    for (int t = 0; t < 3; t++) wait_tick();
    rd_chk("mode1_duty", 2, 6);
    chk("mode1_sel", int'(sel), 2);
    mode = 1'b0; js_u = 1'b0; js_r = 1'b0;

    // Write beats jog on the same channel in the tick cycle.
    do_reset();
    wait_tick();
    js_u = 1'b1;
    repeat (3) step_clk();
    chk("tick_align", int'(tick), 1);
    write(0, 3);
    js_u = 1'b0;
    wait_tick(); rd_chk("wr_win_a", 0, 2);
    wait_tick(); rd_chk("wr_win_b", 0, 3);
    wait_tick(); rd_chk("wr_win_c", 0, 3);

    // Reset mid-period and mid-operation.
    write(2, 8);
    for (int t = 0; t < 5; t++) wait_tick();
    rd_chk("pre_rst", 2, 8);
    repeat (12) step_clk();
    count_high(2, cnt); chk("pwm2_pre_rst", cnt, 8);
    repeat (3) step_clk();
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
    chk("mid_rst_pwm", int'(pwm), 0);
    chk("mid_rst_sel", int'(sel), 0);
    chk("mid_rst_t0", int'(tick), 0);
    for (int c = 0; c < 3; c++) rd_chk("mid_rst_rd", c, 0);
    step_clk(); chk("mid_rst_t1", int'(tick), 0);
    step_clk(); chk("mid_rst_t2", int'(tick), 0);
    step_clk(); chk("mid_rst_t3", int'(tick), 1);
    step_clk();
    rd_chk("post_rst_rd", 2, 0);
    count_high(2, cnt); chk("post_rst_pwm2", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
